// File: rtl/grid_ram_arbiter.sv
// rtl/grid_ram_arbiter.sv - shares the snake-grid RAM between renderer and game engine, opening a game window in vblank
// Optional GRID_FRAME_DIV_EN: open the window only on every FRAME_DIV-th frame_tik rising edge.
module grid_ram_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 2,
    parameter int WINDOW_CYC = 1600,
    parameter int FRAME_DIV  = 8
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic              display_area_i,
    input  logic              frame_tik_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic [DATA_W-1:0] vid_rdata_o,
    output logic              vid_valid_o,
    input  logic              game_req_i,
    input  logic              game_we_i,
    input  logic [ADDR_W-1:0] game_addr_i,
    input  logic [DATA_W-1:0] game_wdata_i,
    input  logic              game_done_i,
    output logic              game_gnt_o,
    output logic [DATA_W-1:0] game_rdata_o,
    output logic              game_rvalid_o,
    output logic              update_start_o,
    output logic              overrun_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    localparam int CNT_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    typedef enum logic {S_VIDEO, S_UPDATE} state_t;

    state_t             state_q, state_d;
    logic               tik_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               update_start_q, update_start_d;
    logic               overrun_q, overrun_d;
    logic               vid_valid_q, game_rvalid_q;
    logic               vid_win, game_gnt, game_read, tik_rise, open_win;

    // Video is masked while reset is held so the RAM port reads address 0 during reset.
    assign vid_win   = vid_req_i & reset;
    assign game_gnt  = (state_q == S_UPDATE) & game_req_i & ~vid_req_i;
    assign game_read = game_gnt & ~game_we_i;
    assign tik_rise  = frame_tik_i & ~tik_q;

    always_comb begin
        div_d = div_q;
        if (tik_rise) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
`ifdef GRID_FRAME_DIV_EN
        open_win = tik_rise & (div_d == '0);
`else
        open_win = tik_rise;
`endif
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        update_start_d = 1'b0;
        overrun_d      = overrun_q;
        case (state_q)
            S_VIDEO: begin
                if (open_win) begin
                    state_d        = S_UPDATE;
                    cnt_d          = '0;
                    update_start_d = 1'b1;
                end
            end
            S_UPDATE: begin
                // A grant in the closing cycle still completes; only an ungranted request is an overrun.
                if (game_done_i || (cnt_q == CNT_LAST) || display_area_i) begin
                    state_d = S_VIDEO;
                    if (game_req_i && !game_gnt) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_VIDEO;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q        <= S_VIDEO;
            tik_q          <= 1'b0;
            cnt_q          <= '0;
            div_q          <= '0;
            update_start_q <= 1'b0;
            overrun_q      <= 1'b0;
            vid_valid_q    <= 1'b0;
            game_rvalid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            tik_q          <= frame_tik_i;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            update_start_q <= update_start_d;
            overrun_q      <= overrun_d;
            vid_valid_q    <= vid_win;
            game_rvalid_q  <= game_read;
        end
    end

    assign ram_addr_o     = vid_win ? vid_addr_i : (game_gnt ? game_addr_i : '0);
    assign ram_we_o       = game_gnt & game_we_i;
    assign ram_wdata_o    = (game_gnt & game_we_i) ? game_wdata_i : '0;
    assign game_gnt_o     = game_gnt;
    assign vid_rdata_o    = ram_rdata_i;
    assign game_rdata_o   = ram_rdata_i;
    assign vid_valid_o    = vid_valid_q;
    assign game_rvalid_o  = game_rvalid_q;
    assign update_start_o = update_start_q;
    assign overrun_o      = overrun_q;
endmodule
